pkt_buffer: RTL and testbench
=============================

PKT_BUFFER -- requirements
Module: pkt_buffer

Interface
REQ-001 Parameter BASE_ADDR, default 23'h000000, word address the buffer presents as region_begin.
REQ-002 Parameter DEPTH, default 256, buffer capacity in 32-bit words (power of two).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_l  in  1  asynchronous active-low reset.
REQ-005 spi_we  in  1  SPI controller writes spi_wdata into the next fill slot.
REQ-006 spi_wdata  in  32  packet word from SPI.
REQ-007 spi_last  in  1  qualifies spi_we; marks the final word of the packet.
REQ-008 pkt_avail  out  1  complete packet held; DPR may parse.
REQ-009 dpr_done  in  1  DPR finished the packet; release the buffer.
REQ-010 region_begin  out  23  always BASE_ADDR.
REQ-011 region_end  out  23  BASE_ADDR + stored word count.
REQ-012 ptr  in  23  requester word address.
REQ-013 r_en  in  1  read request.
REQ-014 w_en  in  1  write request; r_en takes precedence if both are high.
REQ-015 data_store  in  32  write data.
REQ-016 data_load  out  32  read data, valid while done=1.
REQ-017 done  out  1  one-cycle completion pulse per accepted request.
REQ-018 err  out  1  sticky: out-of-range access or fill overrun.

Function
REQ-019 Fill states: EMPTY (accepts spi_we), READY (pkt_avail=1), DRAIN (release pending).
REQ-020 EMPTY: each spi_we writes mem[fill_cnt] and increments fill_cnt.
REQ-021 EMPTY: spi_we with spi_last -> READY next cycle; region_end = BASE_ADDR + count including the last word.
REQ-022 EMPTY: spi_we while fill_cnt==DEPTH-1 without spi_last -> word stored, READY, err set.
REQ-023 spi_we in READY or DRAIN: data dropped, err set, count unchanged.
REQ-024 Request states: R_IDLE, R_ACCEPT, R_DONE, R_REARM.
REQ-025 Accept a request only in READY and R_IDLE, when r_en|w_en=1 -> R_ACCEPT.
REQ-026 R_ACCEPT latches ptr and data_store; computes idx = ptr - BASE_ADDR, truncated to log2(DEPTH) bits.
REQ-027 In range means BASE_ADDR <= ptr < region_end.
REQ-028 In-range read: memory read in R_ACCEPT; R_DONE drives done=1 and data_load=mem[idx] (2-cycle latency, request edge to done).
REQ-029 In-range write: mem[idx] written in R_ACCEPT; R_DONE drives done=1; data_load holds its previous value.
REQ-030 Out-of-range access: no memory effect; done=1 with data_load=0; err set.
REQ-031 R_DONE -> R_REARM; R_REARM -> R_IDLE only once r_en=0 and w_en=0, so one held request yields exactly one done.
REQ-032 READY with dpr_done=1: if R_IDLE/R_REARM -> EMPTY next cycle; otherwise -> DRAIN.
REQ-033 DRAIN: the in-flight request finishes and its done pulses; then -> EMPTY.
REQ-034 Entering EMPTY: pkt_avail=0, fill_cnt=0, region_end=BASE_ADDR; memory contents are not cleared.
REQ-035 dpr_done ignored in EMPTY.
REQ-036 Requests outside READY are never accepted and receive no done.
REQ-037 pkt_avail=1 exactly in READY.

Reset
REQ-038 rst_l=0, at any time including mid-fill or mid-request, immediately forces: EMPTY, R_IDLE, pkt_avail=0, done=0, data_load=0, err=0, fill_cnt=0, region_end=BASE_ADDR.
REQ-039 After reset deasserts, the first spi_we is stored at index 0.

Verification
REQ-040 Fill 5 words 0x10..0x14, last on the 5th -> pkt_avail=1 the next cycle, region_end=5; read ptr=3 -> done exactly 2 cycles after r_en rises, data_load=0x13.
REQ-041 Hold r_en high for 10 cycles at ptr=0 -> exactly one done pulse; drop r_en one cycle, reassert -> second done.
REQ-042 Write 0xDEADBEEF at ptr=2, then read ptr=2 -> 0xDEADBEEF; read ptr=5 (==region_end) -> done, data_load=0, err=1.
REQ-043 Assert dpr_done in the same cycle r_en is accepted -> done still pulses, then pkt_avail=0; the next fill is stored from index 0.
REQ-044 Write DEPTH words with no spi_last -> READY, err=1, region_end=BASE_ADDR+DEPTH; extra spi_we in READY -> err stays 1, contents unchanged.
REQ-045 Pulse rst_l low in R_ACCEPT during a read -> no done pulse; all outputs take their reset values; refill and read back correctly.

Source files
------------

// File: rtl/pkt_buffer_if.sv
// Requester port of pkt_buffer: address/data request with a one-cycle done pulse.
`timescale 1ns/1ps
interface pkt_buffer_if;
  logic [22:0] ptr;
  logic        r_en;
  logic        w_en;
  logic [31:0] data_store;
  logic [31:0] data_load;
  logic        done;

  // Requester side (e.g. the DPR parser).
  modport master (
    output ptr, r_en, w_en, data_store,
    input  data_load, done
  );

  // Buffer side.
  modport slave (
    input  ptr, r_en, w_en, data_store,
    output data_load, done
  );
endinterface

// File: rtl/pkt_buffer.sv
// pkt_buffer: holds one packet filled word-by-word from SPI and serves
// read/write requests into it until the consumer releases the buffer.
`timescale 1ns/1ps
module pkt_buffer #(
  parameter logic [22:0] BASE_ADDR = 23'h000000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        spi_we,
  input  logic [31:0] spi_wdata,
  input  logic        spi_last,
  output logic        pkt_avail,
  input  logic        dpr_done,
  output logic [22:0] region_begin,
  output logic [22:0] region_end,
  output logic        err,
  pkt_buffer_if.slave req
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {EMPTY, READY, DRAIN} fill_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DONE, R_REARM} req_state_t;

  fill_state_t      fill_state, fill_next;
  req_state_t       req_state, req_next;
  logic [CNT_W-1:0] fill_cnt;
  logic [22:0]      ptr_q;
  logic [31:0]      data_q;
  logic             read_q;
  logic [31:0]      load_q;
  logic             done_q;
  logic [31:0]      mem [DEPTH];

  logic             fill_take;
  logic             fill_full;
  logic             accept;
  logic             in_range;
  logic [22:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_wdata;

  assign fill_take = (fill_state == EMPTY) && spi_we;
  assign fill_full = (fill_cnt == CNT_W'(DEPTH - 1));
  assign accept    = (fill_state == READY) && (req_state == R_IDLE) && (req.r_en || req.w_en);

  // Range test uses the full offset; only the low bits address the array.
  assign offset   = ptr_q - BASE_ADDR;
  assign in_range = (ptr_q >= BASE_ADDR) && (offset < 23'(fill_cnt));
  assign idx      = offset[IDX_W-1:0];

  // Fill writes only happen in EMPTY and request writes only after an accept
  // in READY, so one shared write port never sees both at once.
  assign mem_we    = fill_take || ((req_state == R_ACCEPT) && !read_q && in_range);
  assign mem_addr  = fill_take ? fill_cnt[IDX_W-1:0] : idx;
  assign mem_wdata = fill_take ? spi_wdata : data_q;

  assign pkt_avail      = (fill_state == READY);
  assign region_begin   = BASE_ADDR;
  assign region_end     = BASE_ADDR + 23'(fill_cnt);
  assign req.data_load  = load_q;
  assign req.done       = done_q;

  // State registers for the fill and request machines.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fill_state <= EMPTY;
      req_state  <= R_IDLE;
    end else begin
      fill_state <= fill_next;
      req_state  <= req_next;
    end
  end

  // Fill machine next state: a release only waits if a request is in flight.
  // NOTE: next-state gets a default before the case so no latch is inferred.
  always_comb begin
    fill_next = fill_state;
    case (fill_state)
      EMPTY:   if (fill_take && (spi_last || fill_full)) fill_next = READY;
      READY:   if (dpr_done) begin
                 if ((req_state == R_REARM) || ((req_state == R_IDLE) && !accept))
                   fill_next = EMPTY;
                 else
                   fill_next = DRAIN;
               end
      DRAIN:   if (req_state != R_ACCEPT) fill_next = EMPTY;
      default: fill_next = EMPTY;
    endcase
  end

  // Request machine next state: rearm only after the request lines drop.
  always_comb begin
    req_next = req_state;
    case (req_state)
      R_IDLE:   if (accept) req_next = R_ACCEPT;
      R_ACCEPT: req_next = R_DONE;
      R_DONE:   req_next = R_REARM;
      R_REARM:  if (!req.r_en && !req.w_en) req_next = R_IDLE;
      default:  req_next = R_IDLE;
    endcase
  end

  // Fill counter, request capture, read data, done pulse and sticky error.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fill_cnt <= '0;
      ptr_q    <= '0;
      data_q   <= '0;
      read_q   <= 1'b0;
      load_q   <= '0;
      done_q   <= 1'b0;
      err      <= 1'b0;
    end else begin
      done_q <= (req_state == R_ACCEPT);
      if (accept) begin
        ptr_q  <= req.ptr;
        data_q <= req.data_store;
        read_q <= req.r_en;
      end
      if (req_state == R_ACCEPT) begin
        if (!in_range) begin
          load_q <= '0;
          err    <= 1'b1;
        end else if (read_q) begin
          load_q <= mem[idx];
        end
      end
      if (fill_take) begin
        fill_cnt <= fill_cnt + CNT_W'(1);
        if (fill_full && !spi_last) err <= 1'b1;
      end
      if (spi_we && (fill_state != EMPTY)) err <= 1'b1;
      if ((fill_state != EMPTY) && (fill_next == EMPTY)) fill_cnt <= '0;
    end
  end

  // Packet storage write port.
  // NOTE: the array has no reset; its contents are only visible once a fill rewrites them.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
endmodule

// File: tb/tb_pkt_buffer.sv
// Self-checking bench for pkt_buffer: directed table, multi-cycle corner
// sequences and randomized packets against a packet-level reference model.
`timescale 1ns/1ps
module tb_pkt_buffer;
  localparam logic [22:0] BASE  = 23'h000400;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        spi_we;
  logic [31:0] spi_wdata;
  logic        spi_last;
  logic        pkt_avail;
  logic        dpr_done;
  logic [22:0] region_begin;
  logic [22:0] region_end;
  logic        err;

  pkt_buffer_if bus();

  pkt_buffer #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .spi_we       (spi_we),
    .spi_wdata    (spi_wdata),
    .spi_last     (spi_last),
    .pkt_avail    (pkt_avail),
    .dpr_done     (dpr_done),
    .region_begin (region_begin),
    .region_end   (region_end),
    .err          (err),
    .req          (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: one packet as an array plus a word count.
  logic [31:0] m_mem [DEPTH];
  int          m_cnt;
  bit          m_ready;
  bit          m_err;
  logic [31:0] m_load;

  function automatic void model_reset();
    m_cnt = 0; m_ready = 0; m_err = 0; m_load = '0;
  endfunction

  function automatic void model_word(input logic [31:0] w, input bit last);
    if (m_ready) m_err = 1;
    else begin
      m_mem[m_cnt] = w;
      m_cnt++;
      if (last || m_cnt == DEPTH) begin
        m_ready = 1;
        if (!last) m_err = 1;
      end
    end
  endfunction

  function automatic void model_req(input bit wr, input logic [22:0] p, input logic [31:0] wd);
    int off = int'(p) - int'(BASE);
    if (off >= 0 && off < m_cnt) begin
      if (wr) m_mem[off] = wd;
      else    m_load = m_mem[off];
    end else begin
      m_load = '0;
      m_err  = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_l = 1'b0; spi_we = 1'b0; spi_wdata = '0; spi_last = 1'b0; dpr_done = 1'b0;
    bus.ptr = '0; bus.r_en = 1'b0; bus.w_en = 1'b0; bus.data_store = '0;
    tick(); tick();
    #2 rst_l = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic send_words(input logic [31:0] words[$], input bit with_last);
    foreach (words[i]) begin
      spi_we    = 1'b1;
      spi_wdata = words[i];
      spi_last  = with_last && (i == words.size() - 1);
      tick();
      model_word(words[i], spi_last);
    end
    spi_we = 1'b0; spi_last = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, " pkt_avail"}, 32'(pkt_avail), 32'(m_ready));
    check({tag, " region_end"}, 32'(region_end), 32'(BASE) + 32'(m_cnt));
    check({tag, " err"}, 32'(err), 32'(m_err));
  endtask

  task automatic release_pkt(input string tag);
    dpr_done = 1'b1;
    tick();
    dpr_done = 1'b0;
    tick();
    m_ready = 0; m_cnt = 0;
    check({tag, " released pkt_avail"}, 32'(pkt_avail), 32'd0);
    check({tag, " released region_end"}, 32'(region_end), 32'(BASE));
  endtask

  // One request held until done, then dropped; checks latency, data, err, pulse width.
  task automatic do_req(input bit wr, input logic [22:0] p, input logic [31:0] wd,
                        input logic [31:0] exp_load, input bit exp_err, input string tag);
    int lat = 0;
    bus.ptr = p; bus.data_store = wd; bus.r_en = !wr; bus.w_en = wr;
    while (bus.done !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 32'd2);
    check({tag, " data_load"}, bus.data_load, exp_load);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    bus.r_en = 1'b0; bus.w_en = 1'b0;
    tick();
    check({tag, " done width"}, 32'(bus.done), 32'd0);
    tick();
  endtask

  typedef struct {
    string       name;
    bit          wr;
    int          off;
    logic [31:0] wdata;
    logic [31:0] exp_load;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(input string n, input bit wr, input int off,
                              input logic [31:0] wd, input logic [31:0] el, input bit ee);
    vec_t v;
    v.name = n; v.wr = wr; v.off = off; v.wdata = wd; v.exp_load = el; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[13];
    logic [31:0] q[$];
    int          cnt;
    int          lat;

    // Packet 0x10..0x14; in-range, boundary and out-of-range accesses.
    vecs[0]  = mk("rd3",        0,  3, 32'h0,        32'h00000013, 0);
    vecs[1]  = mk("rd0",        0,  0, 32'h0,        32'h00000010, 0);
    vecs[2]  = mk("rd4_top",    0,  4, 32'h0,        32'h00000014, 0);
    vecs[3]  = mk("wr2",        1,  2, 32'hDEADBEEF, 32'h00000014, 0);
    vecs[4]  = mk("rd2_new",    0,  2, 32'h0,        32'hDEADBEEF, 0);
    vecs[5]  = mk("wr0",        1,  0, 32'h0BADF00D, 32'hDEADBEEF, 0);
    vecs[6]  = mk("rd0_new",    0,  0, 32'h0,        32'h0BADF00D, 0);
    vecs[7]  = mk("rd5_end",    0,  5, 32'h0,        32'h00000000, 1);
    vecs[8]  = mk("rd1_sticky", 0,  1, 32'h0,        32'h00000011, 1);
    vecs[9]  = mk("wr_below",   1, -1, 32'h12345678, 32'h00000000, 1);
    vecs[10] = mk("rd4_again",  0,  4, 32'h0,        32'h00000014, 1);
    vecs[11] = mk("wr5_end",    1,  5, 32'hAAAA5555, 32'h00000000, 1);
    vecs[12] = mk("rd3_intact", 0,  3, 32'h0,        32'h00000013, 1);

    do_reset();
    check("reset pkt_avail", 32'(pkt_avail), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset data_load", bus.data_load, 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset region_begin", 32'(region_begin), 32'(BASE));
    check("reset region_end", 32'(region_end), 32'(BASE));

    // Directed table.
    q = '{32'h10, 32'h11, 32'h12, 32'h13};
    send_words(q, 1'b0);
    check("fill4 pkt_avail", 32'(pkt_avail), 32'd0);
    q = '{32'h14};
    send_words(q, 1'b1);
    check("fill5 pkt_avail", 32'(pkt_avail), 32'd1);
    check("fill5 region_end", 32'(region_end), 32'(BASE) + 32'd5);
    foreach (vecs[i])
      do_req(vecs[i].wr, 23'(int'(BASE) + vecs[i].off), vecs[i].wdata,
             vecs[i].exp_load, vecs[i].exp_err, vecs[i].name);
    release_pkt("table");

    // Held request yields one done; drop and reassert yields another.
    do_reset();
    q = '{32'h30, 32'h31, 32'h32};
    send_words(q, 1'b1);
    bus.ptr = BASE; bus.r_en = 1'b1;
    cnt = 0;
    repeat (10) begin tick(); if (bus.done === 1'b1) cnt++; end
    check("hold one done", cnt, 32'd1);
    check("hold data_load", bus.data_load, 32'h30);
    bus.r_en = 1'b0;
    tick();
    bus.r_en = 1'b1;
    cnt = 0;
    repeat (6) begin tick(); if (bus.done === 1'b1) cnt++; end
    check("rearm second done", cnt, 32'd1);
    bus.r_en = 1'b0;
    tick(); tick();

    // Release in the same cycle a read is accepted.
    do_reset();
    q = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24};
    send_words(q, 1'b1);
    bus.ptr = BASE + 23'd1; bus.r_en = 1'b1; dpr_done = 1'b1;
    tick();
    dpr_done = 1'b0;
    lat = 1;
    check("drain pkt_avail", 32'(pkt_avail), 32'd0);
    while (bus.done !== 1'b1 && lat < 8) begin tick(); lat++; end
    check("drain latency", lat, 32'd2);
    check("drain data_load", bus.data_load, 32'h21);
    bus.r_en = 1'b0;
    tick(); tick();
    m_ready = 0; m_cnt = 0;
    check("drain end pkt_avail", 32'(pkt_avail), 32'd0);
    check("drain end region_end", 32'(region_end), 32'(BASE));
    // Requests and releases while EMPTY have no effect.
    bus.ptr = BASE; bus.r_en = 1'b1; dpr_done = 1'b1;
    cnt = 0;
    repeat (4) begin tick(); if (bus.done === 1'b1) cnt++; end
    check("empty no done", cnt, 32'd0);
    bus.r_en = 1'b0; dpr_done = 1'b0;
    tick(); tick();
    q = '{32'h77};
    send_words(q, 1'b1);
    check_status("refill");
    do_req(1'b0, BASE, 32'h0, 32'h77, 1'b0, "refill rd0");

    // Overrun: DEPTH words without last, then a dropped extra word.
    do_reset();
    q.delete();
    for (int i = 0; i < DEPTH - 1; i++) q.push_back(32'h100 + 32'(i));
    send_words(q, 1'b0);
    check("pre-overrun pkt_avail", 32'(pkt_avail), 32'd0);
    q = '{32'h100 + 32'(DEPTH - 1)};
    send_words(q, 1'b0);
    check("overrun pkt_avail", 32'(pkt_avail), 32'd1);
    check("overrun err", 32'(err), 32'd1);
    check("overrun region_end", 32'(region_end), 32'(BASE) + 32'(DEPTH));
    q = '{32'hFFFFFFFF};
    send_words(q, 1'b0);
    check("extra region_end", 32'(region_end), 32'(BASE) + 32'(DEPTH));
    check("extra err", 32'(err), 32'd1);
    do_req(1'b0, BASE + 23'(DEPTH - 1), 32'h0, 32'h100 + 32'(DEPTH - 1), 1'b1, "overrun rd top");
    do_req(1'b0, BASE, 32'h0, 32'h100, 1'b1, "overrun rd0");

    // Reset while a read sits in R_ACCEPT.
    do_reset();
    q = '{32'h40, 32'h41, 32'h42, 32'h43};
    send_words(q, 1'b1);
    do_req(1'b0, BASE + 23'd4, 32'h0, 32'h0, 1'b1, "pre-rst oob");
    do_req(1'b0, BASE + 23'd1, 32'h0, 32'h41, 1'b1, "pre-rst rd1");
    bus.ptr = BASE + 23'd2; bus.r_en = 1'b1;
    tick();
    #2 rst_l = 1'b0;
    #3;
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst data_load", bus.data_load, 32'd0);
    check("midrst pkt_avail", 32'(pkt_avail), 32'd0);
    check("midrst err", 32'(err), 32'd0);
    check("midrst region_end", 32'(region_end), 32'(BASE));
    rst_l = 1'b1;
    model_reset();
    cnt = 0;
    repeat (4) begin tick(); if (bus.done === 1'b1) cnt++; end
    check("midrst no done", cnt, 32'd0);
    bus.r_en = 1'b0;
    tick();
    q = '{32'h50, 32'h51, 32'h52};
    send_words(q, 1'b1);
    check_status("post-rst fill");
    do_req(1'b0, BASE, 32'h0, 32'h50, 1'b0, "post-rst rd0");
    do_req(1'b0, BASE + 23'd2, 32'h0, 32'h52, 1'b0, "post-rst rd2");

    // Randomized packets and requests against the model.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      bit with_last = ($urandom_range(0, 3) != 0);
      int len = with_last ? int'($urandom_range(1, DEPTH)) : DEPTH;
      int extra = int'($urandom_range(0, 2));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back($urandom);
      send_words(q, with_last);
      q.delete();
      for (int i = 0; i < extra; i++) q.push_back($urandom);
      send_words(q, 1'b0);
      check_status("rand fill");
      for (int k = 0; k < 10; k++) begin
        bit          wr  = ($urandom_range(0, 2) == 0);
        int          off = int'($urandom_range(0, m_cnt + 1)) - 1;
        logic [22:0] p   = 23'(int'(BASE) + off);
        logic [31:0] wd  = $urandom;
        model_req(wr, p, wd);
        do_req(wr, p, wd, m_load, m_err, "rand req");
      end
      release_pkt("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
